// File: rtl/uart_cmd_parser.sv
// Byte-level command parser between the UART receiver and transmitter.
// Decodes "Lhh<CR|LF>" (set LED) and "?<CR|LF>" (query LED) and queues short ASCII replies.
module uart_cmd_parser #(
    parameter int LED_WIDTH      = 6,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [LED_WIDTH-1:0] led,
    output logic                 cmd_err,
    output logic                 overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, L_H1, L_H2, L_TERM, Q_TERM, RESP} state_t;

    state_t               r_state, w_next;
    logic [LED_WIDTH-1:0] r_led;
    logic [3:0]           r_hi, r_lo;
    logic [7:0]           r_q0, r_q1, r_q2;
    logic [1:0]           r_qlen;
    logic [TW-1:0]        r_tcnt;
    logic                 r_cmd_err, r_overrun;

    logic [4:0] w_hex;
    logic [3:0] w_nib;
    logic       w_is_hex, w_is_term, w_fits, w_expire, w_waiting, w_pop;
    logic [7:0] w_val, w_led8;
    logic       w_err, w_set_led, w_load_k, w_load_q, w_hi_en, w_lo_en;

    // Returns {valid, nibble} for an ASCII hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        w_hex     = hex_decode(rx_data);
        w_is_hex  = w_hex[4];
        w_nib     = w_hex[3:0];
        w_is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        w_val     = {r_hi, r_lo};
        w_fits    = (w_val >> LED_WIDTH) == 8'd0;
        w_led8    = '0;
        w_led8[LED_WIDTH-1:0] = r_led;
        w_waiting = (r_state == L_H1) || (r_state == L_H2) ||
                    (r_state == L_TERM) || (r_state == Q_TERM);
        // A byte landing on the expiry cycle wins over the timeout.
        w_expire  = (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) && !rx_valid;
        w_pop     = (r_state == RESP) && tx_ready;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_set_led = 1'b0;
        w_load_k  = 1'b0;
        w_load_q  = 1'b0;
        w_hi_en   = 1'b0;
        w_lo_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h4C)      w_next = L_H1;
                    else if (rx_data == 8'h3F) w_next = Q_TERM;
                    else if (!w_is_term)       w_err  = 1'b1;
                end
            end
            L_H1: begin
                if (rx_valid) begin
                    if (w_is_hex) begin
                        w_hi_en = 1'b1;
                        w_next  = L_H2;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            L_H2: begin
                if (rx_valid) begin
                    if (w_is_hex) begin
                        w_lo_en = 1'b1;
                        w_next  = L_TERM;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            L_TERM: begin
                if (rx_valid) begin
                    if (w_is_term && w_fits) begin
                        w_set_led = 1'b1;
                        w_load_k  = 1'b1;
                        w_next    = RESP;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            Q_TERM: begin
                if (rx_valid) begin
                    if (w_is_term) begin
                        w_load_q = 1'b1;
                        w_next   = RESP;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            RESP: begin
                if (w_pop && r_qlen == 2'd1) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_err) w_next = RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_q0      <= '0;
            r_q1      <= '0;
            r_q2      <= '0;
            r_qlen    <= '0;
            r_tcnt    <= '0;
            r_cmd_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cmd_err <= w_err;
            if (r_state == RESP && rx_valid) r_overrun <= 1'b1;
            if (w_hi_en)   r_hi  <= w_nib;
            if (w_lo_en)   r_lo  <= w_nib;
            if (w_set_led) r_led <= w_val[LED_WIDTH-1:0];
            if (rx_valid || !w_waiting)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);
            // Reply queue: r_q0 is always the byte on offer; accepts shift it down.
            if (w_err) begin
                r_q0   <= 8'h45;
                r_qlen <= 2'd1;
            end else if (w_load_k) begin
                r_q0   <= 8'h4B;
                r_qlen <= 2'd1;
            end else if (w_load_q) begin
                r_q0   <= hex_char(w_led8[7:4]);
                r_q1   <= hex_char(w_led8[3:0]);
                r_q2   <= 8'h0A;
                r_qlen <= 2'd3;
            end else if (w_pop) begin
                r_q0   <= r_q1;
                r_q1   <= r_q2;
                r_qlen <= r_qlen - 2'd1;
            end
        end
    end

    always_comb begin
        tx_valid = (r_state == RESP);
        tx_data  = r_q0;
        led      = r_led;
        cmd_err  = r_cmd_err;
        overrun  = r_overrun;
    end

endmodule
